writeback_regfile: RTL and testbench
====================================

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-002 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-003 Clk  input  1  rising-edge clock.
REQ-004 Reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 RegWriteSig  input  1  write enable from the MEM/WB register.
REQ-006 MemToRegSig  input  1  selects DmemRdata as the write-back value.
REQ-007 MemToReg2  input  1  selects PC4WB (link write) as the write-back value.
REQ-008 DmemRdata  input  32  load data from the MEM/WB register.
REQ-009 ALUResult  input  32  ALU result from the MEM/WB register.
REQ-010 PC4WB  input  32  PC+4 value from the MEM/WB register.
REQ-011 WriteReg  input  5  destination register index.
REQ-012 ReadReg1, ReadReg2  input  5 each  ID-stage source register indices.
REQ-013 ReadData1, ReadData2  output  32 each  source operand values.
REQ-014 WriteData  output  32  selected write-back value, exported for EX forwarding.
REQ-015 WriteCount  output  32  number of committed register writes.

Function
REQ-016 WriteData SHALL be combinational, with priority: MemToReg2=1 -> PC4WB; else MemToRegSig=1 -> DmemRdata; else ALUResult.
REQ-017 Storage SHALL be 32 x 32-bit registers; register 0 SHALL always read 0 and SHALL never be written.
REQ-018 A write SHALL commit on the Clk rising edge when Reset=1, RegWriteSig=1 and WriteReg!=0, storing WriteData into register[WriteReg].
REQ-019 ReadData1 and ReadData2 SHALL be asynchronous (combinational) reads of register[ReadReg1] and register[ReadReg2].
REQ-020 Both read ports SHALL be independent; identical indices on both ports SHALL return identical data.
REQ-021 WriteCount SHALL increment by 1 on each committed write (REQ-018) and SHALL NOT increment when WriteReg=0 or RegWriteSig=0.
REQ-022 WriteCount SHALL wrap from 0xFFFFFFFF to 0x00000000 with no saturation or flag.
REQ-023 Write latency SHALL be one edge: a committed value is visible on the read ports from the cycle after the edge.
REQ-024 Unselected mux inputs (X or any value) SHALL NOT affect WriteData.

Reset
REQ-025 When Reset=0 at a rising edge, all 32 registers and WriteCount SHALL become 0.
REQ-026 Reset SHALL take priority over a simultaneous write; no write and no count increment SHALL occur on that edge.
REQ-027 While Reset=0, ReadData1 and ReadData2 SHALL reflect the cleared contents (0) from the cycle after the first reset edge.

Configuration
REQ-028 With macro REGFILE_BYPASS_EN defined, a read port whose index equals WriteReg SHALL return WriteData in the same cycle when RegWriteSig=1, WriteReg!=0 and Reset=1.
REQ-029 Without REGFILE_BYPASS_EN, read ports SHALL always return stored contents; a pending write SHALL become visible only after its edge (REQ-023).
REQ-030 Register 0 SHALL read 0 in both configurations, including when WriteReg=0 and RegWriteSig=1.

Verification
REQ-031 Reset: hold Reset=0 for 2 cycles after random writes -> all reads return 0 and WriteCount=0.
REQ-032 Mux priority: ALUResult=0x11, DmemRdata=0x22, PC4WB=0x33 with {MemToReg2,MemToRegSig}=00/01/10/11 -> WriteData=0x11/0x22/0x33/0x33.
REQ-033 Write then read: write 0xDEADBEEF to r5, then ReadReg1=5 on the next cycle -> ReadData1=0xDEADBEEF and WriteCount=1.
REQ-034 r0 protection: RegWriteSig=1, WriteReg=0, ALUResult=0xFFFFFFFF -> ReadData2 for index 0 stays 0 and WriteCount is unchanged.
REQ-035 Same-cycle hazard: r7=0x1, then write 0x2 to r7 with ReadReg1=7 -> ReadData1=0x2 with REGFILE_BYPASS_EN, 0x1 without; 0x2 on the next cycle in both configurations.
REQ-036 Reset collision and wrap: force WriteCount to 0xFFFFFFFF and commit one write -> WriteCount=0; a write with Reset=0 on the same edge -> target register reads 0 and WriteCount=0.

Source files
------------

// File: rtl/writeback_regfile_if.sv
// writeback_regfile_if: MEM/WB write-back and ID-stage read signals for the register file.
interface writeback_regfile_if;
  logic        RegWriteSig;
  logic        MemToRegSig;
  logic        MemToReg2;
  logic [31:0] DmemRdata;
  logic [31:0] ALUResult;
  logic [31:0] PC4WB;
  logic [4:0]  WriteReg;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] WriteData;
  logic [31:0] WriteCount;
  modport master (
    output RegWriteSig, MemToRegSig, MemToReg2, DmemRdata, ALUResult, PC4WB,
           WriteReg, ReadReg1, ReadReg2,
    input  ReadData1, ReadData2, WriteData, WriteCount
  );
  modport slave (
    input  RegWriteSig, MemToRegSig, MemToReg2, DmemRdata, ALUResult, PC4WB,
           WriteReg, ReadReg1, ReadReg2,
    output ReadData1, ReadData2, WriteData, WriteCount
  );
endinterface

// File: rtl/writeback_regfile.sv
// writeback_regfile: write-back mux plus 32x32 register file with commit counter.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module writeback_regfile (
  input logic Clk,
  input logic Reset,
  writeback_regfile_if.slave bus
);
  logic [31:0] regs [32];
  logic [31:0] writeCountQ;
  logic [31:0] writeData;
  logic        commit;
  assign writeData = bus.MemToReg2 ? bus.PC4WB : bus.MemToRegSig ? bus.DmemRdata : bus.ALUResult;
  assign commit = bus.RegWriteSig && (bus.WriteReg != 5'd0);
  function automatic logic [31:0] readPort(input logic [4:0] idx);
`ifdef REGFILE_BYPASS_EN
    return (idx == 5'd0) ? 32'd0 :
           (commit && Reset && idx == bus.WriteReg) ? writeData : regs[idx];
`else
    return (idx == 5'd0) ? 32'd0 : regs[idx];
`endif
  endfunction
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      writeCountQ <= 32'd0;
    end else if (commit) begin
      regs[bus.WriteReg] <= writeData;
      writeCountQ <= writeCountQ + 32'd1;
    end
  end
  assign bus.WriteData  = writeData;
  assign bus.WriteCount = writeCountQ;
  assign bus.ReadData1  = readPort(bus.ReadReg1);
  assign bus.ReadData2  = readPort(bus.ReadReg2);
endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: directed checks of write-back mux, register file, reset and counter.
module tb_writeback_regfile;
  logic Clk = 1'b0;
  logic Reset;
  int checks = 0;
  int errors = 0;
  writeback_regfile_if bus ();
  writeback_regfile dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic setWrite(input logic we, input logic [4:0] wr, input logic m2, input logic mr,
                          input logic [31:0] alu, input logic [31:0] dm, input logic [31:0] pc);
    bus.RegWriteSig = we;
    bus.WriteReg    = wr;
    bus.MemToReg2   = m2;
    bus.MemToRegSig = mr;
    bus.ALUResult   = alu;
    bus.DmemRdata   = dm;
    bus.PC4WB       = pc;
  endtask
  initial begin
    Reset = 1'b0;
    setWrite(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    bus.ReadReg1 = 5'd0;
    bus.ReadReg2 = 5'd0;
    tick();
    tick();
    check("reset_count", bus.WriteCount, 32'd0);
    Reset = 1'b1;
    bus.ReadReg1 = 5'd3;
    bus.ReadReg2 = 5'd9;
    check("reset_rd1", bus.ReadData1, 32'd0);
    // Populate a few registers, then clear them with a two-cycle reset
    setWrite(1'b1, 5'd3, 1'b0, 1'b0, 32'hA5A5_0003, 32'd0, 32'd0);
    tick();
    setWrite(1'b1, 5'd9, 1'b0, 1'b0, 32'h5A5A_0009, 32'd0, 32'd0);
    tick();
    bus.RegWriteSig = 1'b0;
    #1;
    check("pre_reset_r3", bus.ReadData1, 32'hA5A5_0003);
    check("pre_reset_count", bus.WriteCount, 32'd2);
    Reset = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    #1;
    check("post_reset_r3", bus.ReadData1, 32'd0);
    check("post_reset_r9", bus.ReadData2, 32'd0);
    check("post_reset_count", bus.WriteCount, 32'd0);
    setWrite(1'b0, 5'd1, 1'b0, 1'b0, 32'h11, 32'h22, 32'h33);
    #1;
    check("mux_00", bus.WriteData, 32'h11);
    bus.MemToRegSig = 1'b1;
    #1;
    check("mux_01", bus.WriteData, 32'h22);
    bus.MemToReg2 = 1'b1;
    bus.MemToRegSig = 1'b0;
    #1;
    check("mux_10", bus.WriteData, 32'h33);
    bus.MemToRegSig = 1'b1;
    #1;
    check("mux_11", bus.WriteData, 32'h33);
    bus.ALUResult = 32'hFFFF_0000;
    bus.DmemRdata = 32'h0000_FFFF;
    #1;
    check("mux_unsel", bus.WriteData, 32'h33);
    setWrite(1'b1, 5'd5, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'h0);
    tick();
    bus.RegWriteSig = 1'b0;
    bus.ReadReg1 = 5'd5;
    bus.ReadReg2 = 5'd5;
    #1;
    check("wr_r5_rd1", bus.ReadData1, 32'hDEAD_BEEF);
    check("wr_r5_rd2", bus.ReadData2, 32'hDEAD_BEEF);
    check("wr_r5_count", bus.WriteCount, 32'd1);
    setWrite(1'b1, 5'd12, 1'b0, 1'b1, 32'h1, 32'hCAFE_0012, 32'h2);
    tick();
    setWrite(1'b1, 5'd13, 1'b1, 1'b1, 32'h1, 32'h2, 32'h0000_1004);
    tick();
    bus.RegWriteSig = 1'b0;
    bus.ReadReg1 = 5'd12;
    bus.ReadReg2 = 5'd13;
    #1;
    check("load_r12", bus.ReadData1, 32'hCAFE_0012);
    check("link_r13", bus.ReadData2, 32'h0000_1004);
    check("load_link_count", bus.WriteCount, 32'd3);
    setWrite(1'b1, 5'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    bus.ReadReg2 = 5'd0;
    #1;
    check("r0_same_cycle", bus.ReadData2, 32'd0);
    tick();
    bus.RegWriteSig = 1'b0;
    #1;
    check("r0_after", bus.ReadData2, 32'd0);
    check("r0_count", bus.WriteCount, 32'd3);
    setWrite(1'b1, 5'd7, 1'b0, 1'b0, 32'h1, 32'h0, 32'h0);
    tick();
    bus.ALUResult = 32'h2;
    bus.ReadReg1 = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("hazard_same", bus.ReadData1, 32'h2);
`else
    check("hazard_same", bus.ReadData1, 32'h1);
`endif
    tick();
    bus.RegWriteSig = 1'b0;
    #1;
    check("hazard_next", bus.ReadData1, 32'h2);
    check("hazard_count", bus.WriteCount, 32'd5);
    force dut.writeCountQ = 32'hFFFF_FFFF;
    #1;
    release dut.writeCountQ;
    #1;
    check("preset_count", bus.WriteCount, 32'hFFFF_FFFF);
    setWrite(1'b1, 5'd10, 1'b0, 1'b0, 32'h77, 32'h0, 32'h0);
    tick();
    bus.RegWriteSig = 1'b0;
    bus.ReadReg1 = 5'd10;
    #1;
    check("wrap_count", bus.WriteCount, 32'd0);
    check("wrap_r10", bus.ReadData1, 32'h77);
    setWrite(1'b1, 5'd11, 1'b0, 1'b0, 32'h99, 32'h0, 32'h0);
    tick();
    setWrite(1'b1, 5'd11, 1'b0, 1'b0, 32'hAB, 32'h0, 32'h0);
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    bus.RegWriteSig = 1'b0;
    bus.ReadReg1 = 5'd11;
    bus.ReadReg2 = 5'd10;
    #1;
    check("collide_r11", bus.ReadData1, 32'd0);
    check("collide_r10", bus.ReadData2, 32'd0);
    check("collide_count", bus.WriteCount, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
